// File: rtl/sram_arb_pkg.sv
`timescale 1ns/1ps
// sram_arb_pkg: shared types and constants for the SRAM pixel arbiter.
//   arb_state_t     - arbiter FSM states
//   *_DEFAULT       - default address/data widths and read-streak limit
//   STREAK_W        - width of the consecutive-read counter
//   STABLE_W        - width of the FIFO-head stability counter
//   stable_update() - saturating stability counter step
package sram_arb_pkg;

  localparam int ADDR_WIDTH_DEFAULT      = 17;
  localparam int DATA_WIDTH_DEFAULT      = 8;
  localparam int MAX_READ_STREAK_DEFAULT = 4;

  localparam int STREAK_W = 3;
  localparam int STABLE_W = 2;

  // Head entry is trustworthy once the counter reaches this value.
  localparam logic [STABLE_W-1:0] STABLE_READY = 2'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ADDR   = 3'd1,
    RD_WAIT   = 3'd2,
    RD_SAMPLE = 3'd3,
    WR_SETUP  = 3'd4,
    WR_PULSE  = 3'd5,
    WR_HOLD   = 3'd6
  } arb_state_t;

  // The FIFO output register lags its read pointer, so the head is only
  // considered valid after two quiet cycles (no pop, not empty).
  function automatic logic [STABLE_W-1:0] stable_update(
    input logic                clear,
    input logic [STABLE_W-1:0] cur
  );
    logic [STABLE_W-1:0] nxt;
    if (clear) begin
      nxt = {STABLE_W{1'b0}};
    end else if (cur == STABLE_READY) begin
      nxt = cur;
    end else begin
      nxt = cur + {{(STABLE_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sram_pin_driver.sv
`timescale 1ns/1ps
// sram_pin_driver: registered output stage for the asynchronous SRAM pins.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   load_addr, load_dq    - update the address / write-data registers
//   next_addr, next_dq    - values loaded on the next edge
//   next_cs_n, next_oe_n,
//   next_we_n, next_dq_oe - requested strobe levels for the next cycle
//   sram_addr, sram_dq_out, sram_dq_oe,
//   sram_cs_n, sram_oe_n, sram_we_n - registered SRAM pins
module sram_pin_driver #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_addr,
  input  logic                  load_dq,
  input  logic [ADDR_WIDTH-1:0] next_addr,
  input  logic [DATA_WIDTH-1:0] next_dq,
  input  logic                  next_cs_n,
  input  logic                  next_oe_n,
  input  logic                  next_we_n,
  input  logic                  next_dq_oe,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dq_out,
  output logic                  sram_dq_oe,
  output logic                  sram_cs_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  logic we_n_safe_s;
  logic dq_oe_safe_s;

  // Output enable wins: a write strobe or pad drive is suppressed whenever
  // the SRAM is being asked to drive the bus, so the two can never fight.
  always_comb begin
    we_n_safe_s  = next_we_n | ~next_oe_n;
    dq_oe_safe_s = next_dq_oe & next_oe_n;
  end

  // Pin registers; reset forces every strobe inactive and the pad to input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_addr   <= {ADDR_WIDTH{1'b0}};
      sram_dq_out <= {DATA_WIDTH{1'b0}};
      sram_dq_oe  <= 1'b0;
      sram_cs_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      if (load_addr) begin
        sram_addr <= next_addr;
      end else begin
        sram_addr <= sram_addr;
      end
      if (load_dq) begin
        sram_dq_out <= next_dq;
      end else begin
        sram_dq_out <= sram_dq_out;
      end
      sram_dq_oe <= dq_oe_safe_s;
      sram_cs_n  <= next_cs_n;
      sram_oe_n  <= next_oe_n;
      sram_we_n  <= we_n_safe_s;
    end
  end

endmodule

// File: rtl/sram_pixel_arbiter.sv
`timescale 1ns/1ps
// sram_pixel_arbiter: arbitrates the external 8-bit asynchronous SRAM between
// buffered CPU pixel writes (FIFO read port) and video pixel reads. Reads win
// unless MAX_READ_STREAK reads have gone by while a write was ready.
// Ports:
//   clk, reset                       - clock, asynchronous active-high reset
//   fifo_addr, fifo_data, fifo_empty - FIFO head entry and empty flag
//   fifo_pop                         - FIFO rd_en, high in the grant cycle
//   vid_req, vid_addr                - pixel read request / address
//   vid_data, vid_valid              - read result and its one-cycle strobe
//   sram_*                           - registered SRAM pins
module sram_pixel_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEFAULT,
  parameter int MAX_READ_STREAK = MAX_READ_STREAK_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] fifo_addr,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_valid,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [DATA_WIDTH-1:0] sram_dq_in,
  output logic                  sram_cs_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_READ_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE   = {{(STREAK_W-1){1'b0}}, 1'b1};

  arb_state_t          state_r;
  logic [STREAK_W-1:0] streak_r;
  logic [STABLE_W-1:0] stable_r;

  logic                  wr_ready_s;
  logic                  grant_rd_s;
  logic                  grant_wr_s;
  logic                  load_addr_s;
  logic                  load_dq_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [DATA_WIDTH-1:0] next_dq_s;
  logic                  next_cs_n_s;
  logic                  next_oe_n_s;
  logic                  next_we_n_s;
  logic                  next_dq_oe_s;

  // IDLE arbitration: reads first, but a ready write is forced through once
  // the read streak has reached its limit.
  always_comb begin
    wr_ready_s = (stable_r == STABLE_READY);
    grant_rd_s = 1'b0;
    grant_wr_s = 1'b0;
    if (state_r == IDLE) begin
      if (vid_req && (!wr_ready_s || (streak_r < STREAK_LIMIT))) begin
        grant_rd_s = 1'b1;
      end else if (wr_ready_s) begin
        grant_wr_s = 1'b1;
      end else begin
        grant_rd_s = 1'b0;
        grant_wr_s = 1'b0;
      end
    end else begin
      grant_rd_s = 1'b0;
      grant_wr_s = 1'b0;
    end
  end

  // The pop must land in the same cycle as the grant so the stability
  // counter sees it early enough to re-qualify the head before the next IDLE.
  assign fifo_pop = grant_wr_s;

  // Pin levels for the next cycle, derived from the state being entered.
  // The write entry is captured straight into the pin registers at the grant
  // and simply held through the rest of the write.
  always_comb begin
    load_addr_s  = 1'b0;
    load_dq_s    = 1'b0;
    next_addr_s  = vid_addr;
    next_dq_s    = fifo_data;
    next_cs_n_s  = 1'b1;
    next_oe_n_s  = 1'b1;
    next_we_n_s  = 1'b1;
    next_dq_oe_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_rd_s) begin
          load_addr_s = 1'b1;
          next_addr_s = vid_addr;
          next_cs_n_s = 1'b0;
          next_oe_n_s = 1'b0;
        end else if (grant_wr_s) begin
          load_addr_s  = 1'b1;
          load_dq_s    = 1'b1;
          next_addr_s  = fifo_addr;
          next_dq_s    = fifo_data;
          next_cs_n_s  = 1'b0;
          next_dq_oe_s = 1'b1;
        end else begin
          load_addr_s = 1'b0;
          load_dq_s   = 1'b0;
        end
      end
      RD_ADDR, RD_WAIT: begin
        next_cs_n_s = 1'b0;
        next_oe_n_s = 1'b0;
      end
      WR_SETUP: begin
        next_cs_n_s  = 1'b0;
        next_we_n_s  = 1'b0;
        next_dq_oe_s = 1'b1;
      end
      WR_PULSE: begin
        next_cs_n_s  = 1'b0;
        next_dq_oe_s = 1'b1;
      end
      default: begin
        next_cs_n_s = 1'b1;
      end
    endcase
  end

  // Arbiter FSM, read streak, head-stability counter and read-result regs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      streak_r  <= {STREAK_W{1'b0}};
      stable_r  <= {STABLE_W{1'b0}};
      vid_data  <= {DATA_WIDTH{1'b0}};
      vid_valid <= 1'b0;
    end else begin
      stable_r  <= stable_update(fifo_pop | fifo_empty, stable_r);
      vid_valid <= 1'b0;
      vid_data  <= vid_data;
      case (state_r)
        IDLE: begin
          if (grant_rd_s) begin
            state_r <= RD_ADDR;
            if (streak_r != STREAK_LIMIT) begin
              streak_r <= streak_r + STREAK_ONE;
            end else begin
              streak_r <= streak_r;
            end
          end else if (grant_wr_s) begin
            state_r  <= WR_SETUP;
            streak_r <= {STREAK_W{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        RD_ADDR: state_r <= RD_WAIT;
        // Data is sampled after two cycles of oe_n low, so vid_data and
        // vid_valid are presented during RD_SAMPLE itself.
        RD_WAIT: begin
          state_r   <= RD_SAMPLE;
          vid_data  <= sram_dq_in;
          vid_valid <= 1'b1;
        end
        RD_SAMPLE: state_r <= IDLE;
        WR_SETUP:  state_r <= WR_PULSE;
        WR_PULSE:  state_r <= WR_HOLD;
        WR_HOLD:   state_r <= IDLE;
        default:   state_r <= IDLE;
      endcase
    end
  end

  sram_pin_driver #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pin_driver (
    .clk         (clk),
    .reset       (reset),
    .load_addr   (load_addr_s),
    .load_dq     (load_dq_s),
    .next_addr   (next_addr_s),
    .next_dq     (next_dq_s),
    .next_cs_n   (next_cs_n_s),
    .next_oe_n   (next_oe_n_s),
    .next_we_n   (next_we_n_s),
    .next_dq_oe  (next_dq_oe_s),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_cs_n   (sram_cs_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n)
  );

endmodule

// File: tb/tb_sram_pixel_arbiter.sv
`timescale 1ns/1ps
// tb_sram_pixel_arbiter: directed self-checking bench for sram_pixel_arbiter
// with a lagging-output FIFO model and a combinational SRAM read model.
module tb_sram_pixel_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] fifo_addr  = '0;
  logic [DW-1:0] fifo_data  = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_pop;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_out;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_in;
  logic          sram_cs_n;
  logic          sram_oe_n;
  logic          sram_we_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_pixel_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_addr   (fifo_addr),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_pop    (fifo_pop),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_data    (vid_data),
    .vid_valid   (vid_valid),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_cs_n   (sram_cs_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n)
  );

  // SRAM contents: one fixed cell, everything else a simple address hash.
  function automatic logic [DW-1:0] sram_model(input logic [AW-1:0] a);
    if (a == 17'h00010) return 8'hC3;
    else return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  assign sram_dq_in = (!sram_cs_n && !sram_oe_n) ? sram_model(sram_addr) : 8'hEE;

  // FIFO model: the read pointer moves on a pop, the head register follows
  // one cycle later.
  logic [AW-1:0] f_addr [0:15];
  logic [DW-1:0] f_data [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always @(negedge clk) begin
    fifo_empty = (rd_ptr == wr_ptr);
    if (rd_ptr != wr_ptr) begin
      fifo_addr = f_addr[rd_ptr];
      fifo_data = f_data[rd_ptr];
    end
    if (fifo_pop && (rd_ptr < wr_ptr)) rd_ptr = rd_ptr + 1;
  end

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    f_addr[wr_ptr] = a;
    f_data[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Bus monitor: event order, write log, pop times, pin-exclusion violations.
  int              cyc = 0;
  string           ev_str = "";
  logic [AW+DW-1:0] wr_log [$];
  int              pop_cyc [$];
  int              viol_cnt = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (!sram_oe_n && !sram_we_n) viol_cnt = viol_cnt + 1;
      if (sram_dq_oe && !sram_oe_n) viol_cnt = viol_cnt + 1;
      if (!sram_we_n) begin
        wr_log.push_back({sram_addr, sram_dq_out});
        ev_str = {ev_str, "W"};
      end
      if (vid_valid) ev_str = {ev_str, "R"};
      if (fifo_pop) pop_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s: observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  initial begin
    int n_pop, n_we, n_oe, n_match, n_rd, pop_k, we_k, valid_k, got, gap;
    logic [DW-1:0]    rd_data;
    logic [AW+DW-1:0] ent;

    reset    = 1'b1;
    vid_req  = 1'b0;
    vid_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_pins",
          64'({fifo_pop, vid_valid, vid_data, sram_addr, sram_dq_out, sram_dq_oe}),
          64'({1'b0, 1'b0, 8'h00, 17'h00000, 8'h00, 1'b0}));
    check("reset_strobes", 64'({sram_cs_n, sram_oe_n, sram_we_n}), 64'(3'b111));
    @(posedge clk); #1;
    reset = 1'b0;

    // ---- single write, no reads ----
    @(posedge clk); #1;
    push(17'h1ABCD, 8'h5A);
    n_pop = 0; n_we = 0; n_oe = 0; n_match = 0; pop_k = -1; we_k = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (fifo_pop) begin n_pop++; pop_k = k; end
      if (!sram_we_n) begin n_we++; we_k = k; end
      if (sram_dq_oe) n_oe++;
      if (sram_dq_oe && !sram_cs_n && sram_addr == 17'h1ABCD && sram_dq_out == 8'h5A) n_match++;
    end
    check("wr1_pop_count", 64'(n_pop), 64'(1));
    check("wr1_pop_cycle", 64'(pop_k), 64'(2));
    check("wr1_we_count",  64'(n_we),  64'(1));
    check("wr1_we_cycle",  64'(we_k),  64'(4));
    check("wr1_dq_oe_cycles", 64'(n_oe), 64'(3));
    check("wr1_addr_data_cycles", 64'(n_match), 64'(3));

    // ---- 12 streamed reads with 3 pending writes ----
    @(posedge clk); #1;
    ev_str = "";
    wr_log.delete();
    push(17'h00100, 8'h11);
    push(17'h1FFFF, 8'h22);
    push(17'h00000, 8'h33);
    vid_req  = 1'b1;
    vid_addr = 17'h00A00;
    for (int r = 0; r < 12; r++) begin
      got = 0;
      for (int t = 0; t < 20 && got == 0; t++) begin
        @(negedge clk); #1;
        if (vid_valid) got = 1;
      end
      check("stream_valid_seen", 64'(got), 64'(1));
      check("stream_rd_data", 64'(vid_data), 64'(sram_model(vid_addr)));
      if (r < 11) vid_addr = 17'h00A00 + AW'(r + 1);
      else vid_req = 1'b0;
    end
    repeat (12) @(negedge clk);
    #1;
    check_str("stream_order", ev_str, "RRRRWRRRRWRRRRW");
    check("stream_wr_count", 64'(wr_log.size()), 64'(3));
    ent = (wr_log.size() > 0) ? wr_log[0] : '1;
    check("stream_wr0", 64'(ent), 64'({17'h00100, 8'h11}));
    ent = (wr_log.size() > 1) ? wr_log[1] : '1;
    check("stream_wr1", 64'(ent), 64'({17'h1FFFF, 8'h22}));
    ent = (wr_log.size() > 2) ? wr_log[2] : '1;
    check("stream_wr2", 64'(ent), 64'({17'h00000, 8'h33}));

    // ---- single read at 0x00010 ----
    @(posedge clk); #1;
    vid_req  = 1'b1;
    vid_addr = 17'h00010;
    valid_k = -1; n_oe = 0; n_rd = 0; rd_data = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); #1;
      if (!sram_oe_n) n_oe++;
      if (vid_valid) begin
        n_rd++;
        if (valid_k < 0) valid_k = k;
        rd_data = vid_data;
        vid_req = 1'b0;
      end
    end
    check("rd1_valid_cycle", 64'(valid_k), 64'(3));
    check("rd1_data", 64'(rd_data), 64'(8'hC3));
    check("rd1_oe_cycles", 64'(n_oe), 64'(3));
    check("rd1_read_count", 64'(n_rd), 64'(1));

    // ---- back-to-back writes: pop spacing and fresh head per write ----
    @(posedge clk); #1;
    pop_cyc.delete();
    wr_log.delete();
    push(17'h00001, 8'h01);
    push(17'h00002, 8'h02);
    push(17'h1FFFE, 8'hFE);
    repeat (25) @(negedge clk);
    #1;
    check("pop_count", 64'(pop_cyc.size()), 64'(3));
    gap = (pop_cyc.size() > 1) ? pop_cyc[1] - pop_cyc[0] : -1;
    check("pop_gap1", 64'(gap), 64'(4));
    gap = (pop_cyc.size() > 2) ? pop_cyc[2] - pop_cyc[1] : -1;
    check("pop_gap2", 64'(gap), 64'(4));
    ent = (wr_log.size() > 0) ? wr_log[0] : '1;
    check("seq_wr0", 64'(ent), 64'({17'h00001, 8'h01}));
    ent = (wr_log.size() > 1) ? wr_log[1] : '1;
    check("seq_wr1", 64'(ent), 64'({17'h00002, 8'h02}));
    ent = (wr_log.size() > 2) ? wr_log[2] : '1;
    check("seq_wr2", 64'(ent), 64'({17'h1FFFE, 8'hFE}));

    // ---- reset during WR_PULSE ----
    @(posedge clk); #1;
    push(17'h0F0F0, 8'hA1);
    push(17'h10001, 8'hB2);
    got = 0;
    for (int t = 0; t < 20 && got == 0; t++) begin
      @(negedge clk); #1;
      if (!sram_we_n) got = 1;
    end
    check("rst_we_pulse_seen", 64'(got), 64'(1));
    reset = 1'b1;
    #1;
    check("rst_mid_we_n",  64'(sram_we_n),  64'(1));
    check("rst_mid_cs_n",  64'(sram_cs_n),  64'(1));
    check("rst_mid_oe_n",  64'(sram_oe_n),  64'(1));
    check("rst_mid_dq_oe", 64'(sram_dq_oe), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    wr_log.delete();
    repeat (12) @(negedge clk);
    #1;
    check("rst_resume_count", 64'(wr_log.size()), 64'(1));
    ent = (wr_log.size() > 0) ? wr_log[0] : '1;
    check("rst_resume_entry", 64'(ent), 64'({17'h10001, 8'hB2}));

    check("pin_exclusion_violations", 64'(viol_cnt), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_pixel_arbiter.md
# sram_pixel_arbiter

Single-clock (100MHz) arbiter between the CPU pixel-write FIFO's read port and the external 8-bit asynchronous SRAM. Pops buffered {address, data} entries and performs SRAM write cycles. Interleaves higher-priority pixel reads from the video fetch logic, with a starvation guard for writes. All SRAM pins are driven from registers.

## Interface
- ADDR_WIDTH, 17, SRAM/pixel address width
- DATA_WIDTH, 8, SRAM data width
- MAX_READ_STREAK, 4, consecutive reads allowed while a write is pending before one write is forced
- clk  input  1  100MHz arbiter clock, same as the FIFO read clock
- reset  input  1  asynchronous, active-high
- fifo_addr  input  ADDR_WIDTH  FIFO head address (registered FIFO output)
- fifo_data  input  DATA_WIDTH  FIFO head data
- fifo_empty  input  1  FIFO empty flag
- fifo_pop  output  1  one-cycle pop strobe (FIFO rd_en)
- vid_req  input  1  pixel read request; held high until vid_valid
- vid_addr  input  ADDR_WIDTH  read address; stable while vid_req is high
- vid_data  output  DATA_WIDTH  read result
- vid_valid  output  1  one-cycle strobe; vid_data is valid in that cycle
- sram_addr  output  ADDR_WIDTH  SRAM address pins
- sram_dq_out  output  DATA_WIDTH  write data to the pad
- sram_dq_oe  output  1  pad output enable
- sram_dq_in  input  DATA_WIDTH  read data from the pad
- sram_cs_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes

## Operation
- Reset values:
  - fifo_pop=0, vid_valid=0, vid_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0.
  - sram_cs_n, sram_oe_n and sram_we_n are all 1.
  - State is IDLE, streak=0, stable=0.
  - Reset mid-cycle returns the pins to these values immediately. An entry that was already popped but not yet written is lost; this is accepted.
- FIFO head stability: the FIFO output register lags its pointer.
  - Counter stable (0..2, saturating) clears on any cycle with fifo_pop=1 or fifo_empty=1, and increments otherwise.
  - wr_ready = (stable==2).
- States: IDLE, RD_ADDR, RD_WAIT, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE decision, evaluated every cycle:
  - If vid_req=1 and (wr_ready=0 or streak<MAX_READ_STREAK): go to RD_ADDR and increment streak (saturating).
  - Else if wr_ready=1: latch fifo_addr/fifo_data, assert fifo_pop for this cycle, clear streak, go to WR_SETUP.
  - Else stay in IDLE.
- Read: RD_ADDR, then RD_WAIT, then RD_SAMPLE, then IDLE.
  - sram_addr=vid_addr, cs_n=0 and oe_n=0 throughout.
  - In RD_SAMPLE, capture sram_dq_in into vid_data and pulse vid_valid.
- Write: WR_SETUP, then WR_PULSE, then WR_HOLD, then IDLE.
  - addr/dq_out come from the latched entry, cs_n=0 and sram_dq_oe=1 throughout.
  - we_n=0 only in WR_PULSE.
- oe_n and we_n are never both 0. sram_dq_oe=1 only in WR_* states.

## Timing
- Read latency: vid_req first seen high in IDLE at edge N; vid_valid=1 in cycle N+3.
- Back-to-back reads: one read per 4 cycles. vid_req may stay high across successive reads, each with a new address; the next read is not granted in the cycle vid_valid is asserted.
- Write occupancy is 4 cycles including the IDLE pop cycle. wr_ready is re-established 2 cycles after the pop, which is before the next IDLE.
- With vid_req held continuously and fifo non-empty: exactly 4 reads, then 1 write, then repeat.
- All SRAM outputs are registered; pins change only on clk edges.
- Address arithmetic: none; addresses pass through with unchanged width.

## Structure
- Package sram_arb_pkg:
  - state enum
  - ADDR_WIDTH/DATA_WIDTH defaults
  - the two widths of the streak and stable counters
- Sub-module sram_pin_driver:
  - registered SRAM output stage
  - applies the asynchronous reset to the safe pin values
  - enforces mutual exclusion of oe_n and we_n

## Test plan
- FIFO holds {0x1ABCD, 0x5A}, no reads -> fifo_pop pulses once; sram_addr=0x1ABCD and dq_out=0x5A over 3 cycles; we_n low for exactly 1 cycle; dq_oe=1 for 3 cycles.
- Single read at 0x00010, SRAM model returns 0xC3 -> vid_valid in the 3rd cycle after the request, with vid_data=0xC3; oe_n low for 3 cycles.
- vid_req held for 12 reads with 3 FIFO entries pending -> order is 4R, 1W, 4R, 1W, 4R, 1W; no FIFO entry is lost or duplicated.
- fifo_empty deasserts, then pop -> no second pop until 2 cycles after the previous pop; each write uses the new head value.
- Reset asserted during WR_PULSE -> we_n, cs_n and oe_n go to 1 and dq_oe to 0 in the same cycle; after release the block is in IDLE and resumes with the next FIFO entry.
- Assertion over all runs: never oe_n=0 and we_n=0 together; dq_oe=1 implies oe_n=1.
